// File: rtl/jtcastle_romarb_cache.sv
`default_nettype none
// ============================================================================
// jtcastle_romarb_cache : one-word read cache with hit compare and byte mux
// Revision 1.0
// ============================================================================
module jtcastle_romarb_cache #(
   parameter int AW = 18
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   output logic [7:0]    data,
   output logic          ok,
   output logic          miss,
   input  logic          fill,
   input  logic [AW-2:0] fill_tag,
   input  logic [15:0]   fill_word
);

   logic [AW-2:0] tag_q,   tag_d;
   logic [15:0]   word_q,  word_d;
   logic          valid_q, valid_d;
   logic          hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      tag_d   = tag_q;
      word_d  = word_q;
      valid_d = valid_q;
      if (fill) begin
         tag_d   = fill_tag;
         word_d  = fill_word;
         valid_d = 1'b1;
      end
   end

   // Outputs depend only on registered state, so a hit answers with zero latency
   assign hit  = valid_q && (addr[AW-1:1] == tag_q);
   assign ok   = cs && hit;
   assign miss = cs && !hit;
   assign data = addr[0] ? word_q[15:8] : word_q[7:0];

endmodule
`default_nettype wire

// File: rtl/jtcastle_romarb.sv
`default_nettype none
// ============================================================================
// jtcastle_romarb : round-robin SDRAM slot sharing for main and sound CPU ROMs
// Revision 1.0
// ============================================================================
module jtcastle_romarb #(
   parameter int                MAIN_AW    = 18,
   parameter int                SND_AW     = 15,
   parameter int                MEM_AW     = 19,
   parameter logic [MEM_AW-1:0] SND_OFFSET = 'h20000
)(
   input  logic               rst,
   input  logic               clk,
   input  logic               main_cs,
   input  logic [MAIN_AW-1:0] main_addr,
   output logic [7:0]         main_data,
   output logic               main_ok,
   input  logic               snd_cs,
   input  logic [SND_AW-1:0]  snd_addr,
   output logic [7:0]         snd_data,
   output logic               snd_ok,
   output logic               mem_cs,
   output logic [MEM_AW-1:0]  mem_addr,
   input  logic               mem_ok,
   input  logic [15:0]        mem_data
);

   localparam int TW = (MAIN_AW > SND_AW) ? MAIN_AW-1 : SND_AW-1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUSY_MAIN = 2'd1,
      ST_BUSY_SND  = 2'd2
   } state_t;

   state_t            state_q,    state_d;
   logic              last_q,     last_d;
   logic              mem_cs_q,   mem_cs_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [TW-1:0]     tag_q,      tag_d;
   logic              main_miss, snd_miss, main_fill, snd_fill;

   jtcastle_romarb_cache #(.AW(MAIN_AW)) u_main_cache (
      .rst       (rst),
      .clk       (clk),
      .cs        (main_cs),
      .addr      (main_addr),
      .data      (main_data),
      .ok        (main_ok),
      .miss      (main_miss),
      .fill      (main_fill),
      .fill_tag  (tag_q[MAIN_AW-2:0]),
      .fill_word (mem_data)
   );

   jtcastle_romarb_cache #(.AW(SND_AW)) u_snd_cache (
      .rst       (rst),
      .clk       (clk),
      .cs        (snd_cs),
      .addr      (snd_addr),
      .data      (snd_data),
      .ok        (snd_ok),
      .miss      (snd_miss),
      .fill      (snd_fill),
      .fill_tag  (tag_q[SND_AW-2:0]),
      .fill_word (mem_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b0;
         mem_cs_q   <= 1'b0;
         mem_addr_q <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         mem_cs_q   <= mem_cs_d;
         mem_addr_q <= mem_addr_d;
         tag_q      <= tag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      mem_cs_d   = mem_cs_q;
      mem_addr_d = mem_addr_q;
      tag_d      = tag_q;
      main_fill  = 1'b0;
      snd_fill   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // last_q=1 means sound was served last, so main wins a tie
            if (main_miss && (!snd_miss || last_q)) begin
               mem_addr_d = MEM_AW'(main_addr[MAIN_AW-1:1]);
               tag_d      = TW'(main_addr[MAIN_AW-1:1]);
               mem_cs_d   = 1'b1;
               state_d    = ST_BUSY_MAIN;
            end else if (snd_miss) begin
               mem_addr_d = SND_OFFSET + MEM_AW'(snd_addr[SND_AW-1:1]);
               tag_d      = TW'(snd_addr[SND_AW-1:1]);
               mem_cs_d   = 1'b1;
               state_d    = ST_BUSY_SND;
            end
         end
         ST_BUSY_MAIN: begin
            if (mem_ok) begin
               main_fill = 1'b1;
               last_d    = 1'b0;
               mem_cs_d  = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_BUSY_SND: begin
            if (mem_ok) begin
               snd_fill = 1'b1;
               last_d   = 1'b1;
               mem_cs_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            mem_cs_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   assign mem_cs   = mem_cs_q;
   assign mem_addr = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtcastle_romarb.sv
`default_nettype none
// ============================================================================
// tb_jtcastle_romarb : directed and random-latency checks of the ROM arbiter
// Revision 1.0
// ============================================================================
module tb_jtcastle_romarb;

   logic        rst, clk;
   logic        main_cs, snd_cs, mem_cs;
   logic [17:0] main_addr;
   logic [14:0] snd_addr;
   logic [18:0] mem_addr;
   logic [7:0]  main_data, snd_data;
   logic        main_ok, snd_ok, mem_ok;
   logic [15:0] mem_data;

   logic        resp_en, resp_ok, man_ok;
   logic [15:0] resp_data, man_data;
   int          lat_min, lat_max, lat, stab_err;
   logic [18:0] cap;
   logic [18:0] grant_q[$];
   int          n_cmp, n_err;
   bit          tmo;

   assign mem_ok   = resp_ok | man_ok;
   assign mem_data = man_ok ? man_data : resp_data;

   jtcastle_romarb dut (
      .rst(rst), .clk(clk),
      .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
      .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
      .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_data(mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rom(input logic [18:0] a);
      if (a == 19'h8) return 16'hBEEF;
      return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C ^ {5'd0, a[18:16]}};
   endfunction

   function automatic logic [7:0] exp_main(input logic [17:0] a);
      logic [15:0] w;
      w = rom(19'(a[17:1]));
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] exp_snd(input logic [14:0] a);
      logic [15:0] w;
      w = rom(19'h20000 + 19'(a[14:1]));
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SDRAM model: answers every request after lat_min..lat_max cycles
   always begin
      @(negedge clk);
      if (resp_en && mem_cs) begin
         cap = mem_addr;
         grant_q.push_back(cap);
         lat = $urandom_range(lat_max, lat_min);
         for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (!mem_cs || mem_addr !== cap) stab_err++;
         end
         resp_data = rom(cap);
         resp_ok   = 1'b1;
         @(negedge clk);
         resp_ok   = 1'b0;
      end
   end

   task automatic wait_ready(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ((!main_cs || main_ok) && (!snd_cs || snd_ok)) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic step;
      @(negedge clk); #1;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; stab_err = 0;
      rst = 1'b1; main_cs = 0; snd_cs = 0; main_addr = '0; snd_addr = '0;
      resp_en = 1'b1; resp_ok = 0; resp_data = '0; man_ok = 0; man_data = '0;
      lat_min = 3; lat_max = 3;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      step();
      check_eq("rst_mem_cs", 32'(mem_cs), 0);
      check_eq("rst_mem_addr", 32'(mem_addr), 0);
      check_eq("rst_main_ok", 32'(main_ok), 0);
      check_eq("rst_snd_ok", 32'(snd_ok), 0);
      check_eq("rst_main_data", 32'(main_data), 0);

      // main miss, fill, then zero-latency hit on the odd byte
      main_cs = 1; main_addr = 18'h00010; #1;
      check_eq("miss_main_ok", 32'(main_ok), 0);
      step();
      check_eq("miss_mem_cs", 32'(mem_cs), 1);
      check_eq("miss_mem_addr", 32'(mem_addr), 32'h8);
      wait_ready(tmo);
      check_eq("main_fill_tmo", 32'(tmo), 0);
      check_eq("main_data_lo", 32'(main_data), 32'hEF);
      main_addr = 18'h00011; #1;
      check_eq("hit_ok", 32'(main_ok), 1);
      check_eq("hit_data_hi", 32'(main_data), 32'hBE);
      step();
      check_eq("hit_no_mem_cs", 32'(mem_cs), 0);

      // sound miss fills only the sound cache
      main_cs = 0; snd_cs = 1; snd_addr = 15'h0004;
      step();
      check_eq("snd_mem_addr", 32'(mem_addr), 32'h20002);
      wait_ready(tmo);
      check_eq("snd_fill_tmo", 32'(tmo), 0);
      check_eq("snd_data", 32'(snd_data), 32'(exp_snd(15'h0004)));
      main_cs = 1; main_addr = 18'h00004; #1;
      check_eq("snd_no_main_ok", 32'(main_ok), 0);
      main_cs = 0;
      step(); step();

      // simultaneous misses after sound served last: main first
      grant_q.delete();
      main_cs = 1; main_addr = 18'h00100; snd_addr = 15'h0200;
      wait_ready(tmo);
      check_eq("rr1_tmo", 32'(tmo), 0);
      check_eq("rr1_n", grant_q.size(), 2);
      if (grant_q.size() == 2) begin
         check_eq("rr1_first", 32'(grant_q[0]), 32'h00080);
         check_eq("rr1_second", 32'(grant_q[1]), 32'h20100);
      end
      check_eq("rr1_main_data", 32'(main_data), 32'(exp_main(18'h00100)));
      check_eq("rr1_snd_data", 32'(snd_data), 32'(exp_snd(15'h0200)));

      // main served alone, then a simultaneous miss goes to sound first
      snd_cs = 0; main_addr = 18'h00300;
      wait_ready(tmo);
      step(); step();
      grant_q.delete();
      main_addr = 18'h00400; snd_cs = 1; snd_addr = 15'h0600;
      wait_ready(tmo);
      check_eq("rr2_tmo", 32'(tmo), 0);
      check_eq("rr2_n", grant_q.size(), 2);
      if (grant_q.size() == 2) begin
         check_eq("rr2_first", 32'(grant_q[0]), 32'h20300);
         check_eq("rr2_second", 32'(grant_q[1]), 32'h00200);
      end

      // cs dropped mid-access: the access still completes and fills
      snd_cs = 0; main_addr = 18'h01000;
      step();
      check_eq("drop_mem_cs", 32'(mem_cs), 1);
      main_cs = 0;
      tmo = 1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (!mem_cs) begin tmo = 0; break; end
      end
      check_eq("drop_done_tmo", 32'(tmo), 0);
      main_cs = 1; #1;
      check_eq("drop_rehit_ok", 32'(main_ok), 1);
      check_eq("drop_rehit_data", 32'(main_data), 32'(exp_main(18'h01000)));
      step();
      check_eq("drop_rehit_no_cs", 32'(mem_cs), 0);

      // reset in the middle of an access, late mem_ok ignored
      main_cs = 0; step();
      resp_en = 0;
      main_cs = 1; main_addr = 18'h02000;
      step();
      check_eq("rst_mid_cs_before", 32'(mem_cs), 1);
      rst = 1; main_cs = 0; #1;
      check_eq("rst_mid_cs_drop", 32'(mem_cs), 0);
      step();
      rst = 0;
      step(); step();
      man_data = 16'h1234; man_ok = 1;
      step();
      man_ok = 0; resp_en = 1;
      main_cs = 1; #1;
      check_eq("rst_late_ok_miss", 32'(main_ok), 0);
      step();
      check_eq("rst_refetch_cs", 32'(mem_cs), 1);
      wait_ready(tmo);
      check_eq("rst_refetch_tmo", 32'(tmo), 0);
      check_eq("rst_refetch_data", 32'(main_data), 32'(exp_main(18'h02000)));
      main_cs = 0; step(); step();

      // random latency soak
      lat_min = 1; lat_max = 20;
      for (int it = 0; it < 1000; it++) begin
         int sel;
         sel = $urandom_range(0, 2);
         main_cs = (sel != 1);
         snd_cs  = (sel != 0);
         if (main_cs) main_addr = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 15));
         if (snd_cs)  snd_addr  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
         #1;
         wait_ready(tmo);
         check_eq("rand_tmo", 32'(tmo), 0);
         if (main_cs) check_eq("rand_main", 32'(main_data), 32'(exp_main(main_addr)));
         if (snd_cs)  check_eq("rand_snd", 32'(snd_data), 32'(exp_snd(snd_addr)));
         step();
      end
      main_cs = 0; snd_cs = 0;
      repeat (25) step();
      check_eq("addr_stable", 32'(stab_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtcastle_romarb.md
# jtcastle_romarb

Two-port ROM arbiter for the Haunted Castle core. It shares one 16-bit SDRAM read slot between the main CPU program ROM (18-bit byte address, banked) and the sound CPU program ROM (15-bit byte address). Each requester gets a one-word cache, so sequential opcode fetches hit without going to SDRAM. It sits between the main/sound CPU modules and the framework SDRAM bank controller. The requester-side `*_ok` outputs drive CPU `dtack` directly.

## Interface
Parameters:
- `MAIN_AW`, 18: main CPU byte address width.
- `SND_AW`, 15: sound CPU byte address width.
- `MEM_AW`, 19: SDRAM word address width.
- `SND_OFFSET`, 19'h20000: word offset of the sound ROM region in SDRAM. The main ROM region starts at word 0.

Ports:
- `rst` in 1: reset, asynchronous, active-high.
- `clk` in 1: clock, 48 MHz.
- `main_cs` in 1: main CPU read request, level.
- `main_addr` in MAIN_AW: main CPU byte address.
- `main_data` out 8: byte returned to the main CPU.
- `main_ok` out 1: `main_data` is valid for the current `main_addr`.
- `snd_cs` in 1: sound CPU read request, level.
- `snd_addr` in SND_AW: sound CPU byte address.
- `snd_data` out 8: byte returned to the sound CPU.
- `snd_ok` out 1: `snd_data` is valid for the current `snd_addr`.
- `mem_cs` out 1: SDRAM request, held until `mem_ok`.
- `mem_addr` out MEM_AW: SDRAM word address.
- `mem_ok` in 1: one-cycle pulse; `mem_data` is valid on that cycle.
- `mem_data` in 16: SDRAM word.

## Operation
- Each port has a cache: tag (byte address bits [AW-1:1]), 16-bit word, and valid bit.
- Hit: `cs` high, valid set, and `addr[AW-1:1]` equals the tag.
- `*_ok` = `cs & hit`, computed combinationally from registered state.
- `*_data` = cached word[7:0] when `addr[0]`=0, otherwise word[15:8].
- Miss on a port with `cs` high raises a pending request for that port.
- State machine has three states:
  - IDLE: the arbiter picks a pending port. If both ports are pending, it grants the one not served last (round-robin bit `last`, reset 0 = main). It latches `mem_addr` and sets `mem_cs`, then goes to BUSY_MAIN or BUSY_SND.
  - BUSY_MAIN / BUSY_SND: `mem_addr` and `mem_cs` are held stable. On `mem_ok`, the arbiter writes `mem_data` and the captured tag into the owner's cache, sets its valid bit, updates `last` to the owner, drops `mem_cs`, and returns to IDLE.
- Main word address = `main_addr[MAIN_AW-1:1]` zero-extended.
- Sound word address = `SND_OFFSET + snd_addr[SND_AW-1:1]`, computed in MEM_AW bits; overflow wraps.
- Deassertion of `cs` or an address change during BUSY does not abort the access. The cache fills with the captured tag, and a fresh miss is raised next cycle if the address no longer matches.
- A `mem_ok` seen in IDLE is ignored.

## Timing
- Reset values:
  - `mem_cs`=0, `mem_addr`=0.
  - `main_ok`=`snd_ok`=0; `main_data`/`snd_data` follow the reset cache word, which is 0.
  - Valid bits 0, `last`=0, state IDLE.
- Hit latency: 0 cycles (`*_ok` in the same cycle as `cs`/addr).
- Miss latency:
  - cycle 0: `cs` seen, miss.
  - cycle 1: `mem_cs`=1.
  - cycle k: `mem_ok`.
  - cycle k+1: `ok`=1.
- `mem_cs` falls in the cycle after `mem_ok`.
- The earliest next grant is one cycle after that (IDLE is always visited).
- Worst case, a requester waits for one full access by the other port.
- Reset mid-access: `mem_cs` drops immediately and all caches are invalidated. A late `mem_ok` after reset is ignored.

## Structure
- No shared package is needed. `SND_OFFSET` default and state encodings stay local.
- One sub-module is natural: `jtcastle_romarb_cache`, instantiated twice, parameterised by AW. It contains the tag/word/valid registers, hit compare, byte mux and fill port.
- The arbiter FSM, round-robin bit and address mux live in the top module.

## Test plan
- Main reads 0x00010 after reset → `mem_cs` next cycle with `mem_addr`=0x00008. `mem_ok` returns 0xBEEF → `main_ok`=1, `main_data`=0xEF. Then `main_addr`=0x00011 → `main_data`=0xBE with 0 latency and no `mem_cs`.
- Sound reads 0x0004 → `mem_addr`=0x20002. The return fills only the sound cache; `main_ok` stays 0.
- Both miss in the same cycle → main served first, sound second. The next simultaneous miss is served sound first.
- `main_cs` drops during BUSY_MAIN → the cycle completes and `mem_cs` falls after `mem_ok`. Re-requesting the same address hits with no `mem_cs`.
- `rst` pulses while `mem_cs`=1 → `mem_cs`=0 immediately. A `mem_ok` arriving 3 cycles later leaves valid at 0 and a subsequent read misses.
- SDRAM returns after 1 cycle versus 20 cycles (random 1–20 mixed) over 1000 random reads → data always matches the reference ROM model, and `mem_addr` is stable while `mem_cs`=1.
